// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display arbiter:
//   - FSM state encoding (IDLE / SHOW / HOLD)
//   - SSD_BLANK_CODE: out-of-range code that ssd_driver renders as "--"
//   - SSD_DWELL_DEFAULT: default on-screen dwell (0.1 s at 125 MHz)
// ----------------------------------------------------------------------------
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      HOLD = 2'd2
   } ssd_state_e;

   localparam logic [7:0] SSD_BLANK_CODE    = 8'hFF;
   localparam int         SSD_DWELL_DEFAULT = 12_500_000;

endpackage

// File: rtl/ssd_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational wrap-around find-first. Returns the first requesting client
// at or after (ptr+1) mod N_REQ, scanning upward with wrap-around. The client
// at ptr itself is the last candidate considered.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  PW     index of the most recently granted client
//   found out 1      at least one request is set
//   idx   out PW     index of the winning client (0 when found=0)
// ----------------------------------------------------------------------------
module rr_pick
   import ssd_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic             found,
   output logic [PW-1:0]    idx
);

   always_comb begin
      logic [PW-1:0] pos;
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      // Scan from the farthest offset to the nearest so the nearest
      // requester after ptr is the one left in idx.
      for (int off = N_REQ; off >= 1; off--) begin
         pos = PW'((int'(ptr) + off) % N_REQ);
         if (req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/ssd_arbiter.sv
// ----------------------------------------------------------------------------
// ssd_arbiter
// Time-shares the two-digit seven-segment display between N_REQ clients with
// round-robin scheduling and a guaranteed minimum dwell of DWELL cycles per
// grant. Drives ssd_driver.ssd_input; shows SSD_BLANK_CODE when idle.
// Optional feature: define SSD_ARB_PRIORITY_EN to make client 0 urgent
// (it preempts any other owner regardless of the dwell counter).
// Ports:
//   clk        in  1         system clock
//   reset      in  1         asynchronous, active-high
//   req        in  N_REQ     level-sensitive display requests
//   value      in  N_REQ*8   packed client values, client k at [8k+7:8k]
//   grant      out N_REQ     one-hot grant (registered), zero when none
//   owner      out log2(N)   current or last owner (registered)
//   disp_value out 8         value for the display driver (registered)
//   busy       out 1         FSM in SHOW or HOLD
// ----------------------------------------------------------------------------
module ssd_arbiter
   import ssd_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DWELL = SSD_DWELL_DEFAULT,
   parameter int CNT_W = $clog2(DWELL + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*8-1:0]         value,
   output logic [N_REQ-1:0]           grant,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic [7:0]                 disp_value,
   output logic                       busy
);

   localparam int PW = $clog2(N_REQ);

   ssd_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [PW-1:0]     ptr_q,   ptr_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic [7:0]        disp_q,  disp_d;

   logic              pick_found;
   logic [PW-1:0]     pick_idx;
   logic              take;
   logic [PW-1:0]     take_idx;
   logic [7:0]        owner_val;
   logic              cnt_zero;

   rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_val = value[{owner_q, 3'b000} +: 8];
   assign cnt_zero  = (cnt_q == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      disp_d   = disp_q;
      take     = 1'b0;
      take_idx = pick_idx;

      case (state_q)
         IDLE: begin
            disp_d = SSD_BLANK_CODE;
            if (pick_found) take = 1'b1;
         end
         SHOW: begin
            if (!req[owner_q]) begin
               if (!cnt_zero) begin
                  // Released early: keep the last value frozen until the
                  // dwell has run out.
                  state_d = HOLD;
                  grant_d = '0;
               end else if (pick_found) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  disp_d  = SSD_BLANK_CODE;
               end
            end else if (cnt_zero && pick_found && (pick_idx != owner_q)) begin
               // ptr equals the owner, so any other requester wins the pick.
               take = 1'b1;
            end else begin
               disp_d = owner_val;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               if (pick_found) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  disp_d  = SSD_BLANK_CODE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            disp_d  = SSD_BLANK_CODE;
         end
      endcase

`ifdef SSD_ARB_PRIORITY_EN
      if ((state_q != IDLE) && req[0] && (owner_q != '0)) begin
         take     = 1'b1;
         take_idx = '0;
      end
`endif

      if (take) begin
         state_d           = SHOW;
         grant_d           = '0;
         grant_d[take_idx] = 1'b1;
         owner_d           = take_idx;
         ptr_d             = take_idx;
         disp_d            = value[{take_idx, 3'b000} +: 8];
         cnt_d             = CNT_W'(DWELL - 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= PW'(N_REQ - 1);
         grant_q <= '0;
         owner_q <= '0;
         disp_q  <= SSD_BLANK_CODE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         disp_q  <= disp_d;
      end
   end

   assign grant      = grant_q;
   assign owner      = owner_q;
   assign disp_value = disp_q;
   assign busy       = (state_q != IDLE);

endmodule
